// File: rtl/move_select_ctrl.sv
// Chess move-selection controller: cursor and source selection, on-board move
// preview, and a req/ack/done handshake (with timeout) to an external move validator.
module move_select_ctrl #(
  parameter int  BOARD_W    = 8,
  parameter int  BOARD_H    = 8,
  parameter int  PIECE_W    = 4,
  parameter int  EMPTY_CODE = 15,
  parameter int  P1_MAX     = 5,
  parameter int  HOME_X     = 3,
  parameter int  HOME_Y     = 3,
  parameter int  WRAP       = 1,
  parameter int  TIMEOUT    = 1023,
  localparam int XW         = (BOARD_W > 1) ? $clog2(BOARD_W) : 1,
  localparam int YW         = (BOARD_H > 1) ? $clog2(BOARD_H) : 1,
  localparam int PW         = 2 * (XW + YW)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic               player,
  input  logic               curr_player,
  input  logic               dir,
  input  logic               key_dec,
  input  logic               key_inc,
  input  logic               key_enter,
  input  logic               key_cancel,
  input  logic [PIECE_W-1:0] stable_board [BOARD_W][BOARD_H],
  input  logic               val_ack,
  input  logic               val_done,
  input  logic               val_legal,
  output logic [PIECE_W-1:0] disp_board [BOARD_W][BOARD_H],
  output logic               cursor_hl [BOARD_W][BOARD_H],
  output logic               src_hl [BOARD_W][BOARD_H],
  output logic               val_req,
  output logic [PW-1:0]      move_packet,
  output logic [PIECE_W-1:0] sel_piece,
  output logic               moved,
  output logic               rejected,
  output logic               timed_out,
  output logic [15:0]        move_count,
  output logic [2:0]         state
);

  localparam logic [2:0] WAIT_TURN = 3'd0;
  localparam logic [2:0] PIECE_SEL = 3'd1;
  localparam logic [2:0] POS_SEL   = 3'd2;
  localparam logic [2:0] VAL_REQ   = 3'd3;
  localparam logic [2:0] VAL_WAIT  = 3'd4;
  localparam int         CW        = $clog2(TIMEOUT + 1);

  logic [2:0]         state_r, state_s;
  logic [XW-1:0]      cur_x_r, cur_x_s, src_x_r, src_x_s, mv_x_s;
  logic [YW-1:0]      cur_y_r, cur_y_s, src_y_r, src_y_s, mv_y_s;
  logic [PIECE_W-1:0] sel_s, piece_s;
  logic [PW-1:0]      pkt_s;
  logic               val_req_s, moved_s, rejected_s, timed_out_s;
  logic               at_src_s, preview_s, cur_hl_en_s;
  logic [15:0]        count_s;
  logic [CW-1:0]      tmo_r, tmo_s;
  logic [PIECE_W-1:0] disp_s [BOARD_W][BOARD_H];

  function automatic logic own_f(input logic [PIECE_W-1:0] c, input logic p);
    if (c == PIECE_W'(EMPTY_CODE)) begin
      own_f = 1'b0;
    end else if (p) begin
      own_f = (c <= PIECE_W'(P1_MAX));
    end else begin
      own_f = (c > PIECE_W'(P1_MAX));
    end
  endfunction

  // Wrap or saturate one coordinate; valid for any board size, not only powers of two.
  function automatic int step_f(input int v, input int lim, input logic up);
    if (up) begin
      step_f = (v >= lim - 32'sd1) ? ((WRAP != 0) ? 32'sd0 : lim - 32'sd1) : v + 32'sd1;
    end else begin
      step_f = (v <= 32'sd0) ? ((WRAP != 0) ? lim - 32'sd1 : 32'sd0) : v - 32'sd1;
    end
  endfunction

  assign state       = state_r;
  assign piece_s     = stable_board[cur_x_r][cur_y_r];
  assign at_src_s    = (cur_x_r == src_x_r) && (cur_y_r == src_y_r);
  assign preview_s   = (state_r == POS_SEL) || (state_r == VAL_REQ) || (state_r == VAL_WAIT);
  assign cur_hl_en_s = (player == curr_player) && ((state_r == PIECE_SEL) || (state_r == POS_SEL));

  // Candidate cursor after this cycle's movement key; key_dec wins over key_inc.
  always_comb begin
    mv_x_s = cur_x_r;
    mv_y_s = cur_y_r;
    if (key_dec) begin
      if (dir) mv_x_s = XW'(step_f(int'(cur_x_r), BOARD_W, 1'b0));
      else     mv_y_s = YW'(step_f(int'(cur_y_r), BOARD_H, 1'b1));
    end else if (key_inc) begin
      if (dir) mv_x_s = XW'(step_f(int'(cur_x_r), BOARD_W, 1'b1));
      else     mv_y_s = YW'(step_f(int'(cur_y_r), BOARD_H, 1'b0));
    end else begin
      mv_x_s = cur_x_r;
      mv_y_s = cur_y_r;
    end
  end

  // Next-state logic: turn loss > cancel > enter (on pre-move cursor) > movement.
  always_comb begin
    state_s     = state_r;
    cur_x_s     = cur_x_r;
    cur_y_s     = cur_y_r;
    src_x_s     = src_x_r;
    src_y_s     = src_y_r;
    sel_s       = sel_piece;
    pkt_s       = move_packet;
    val_req_s   = val_req;
    moved_s     = 1'b0;
    rejected_s  = 1'b0;
    timed_out_s = 1'b0;
    count_s     = move_count;
    tmo_s       = tmo_r;
    case (state_r)
      WAIT_TURN: begin
        if (enable && (player == curr_player)) begin
          state_s = PIECE_SEL;
          cur_x_s = XW'(HOME_X);
          cur_y_s = YW'(HOME_Y);
          src_x_s = XW'(HOME_X);
          src_y_s = YW'(HOME_Y);
        end else begin
          state_s = WAIT_TURN;
        end
      end
      PIECE_SEL, POS_SEL: begin
        if (player != curr_player) begin
          state_s = WAIT_TURN;
        end else if (!enable) begin
          state_s = state_r;
        end else if ((state_r == POS_SEL) && key_cancel) begin
          state_s = PIECE_SEL;
          cur_x_s = src_x_r;
          cur_y_s = src_y_r;
        end else begin
          cur_x_s = mv_x_s;
          cur_y_s = mv_y_s;
          if (!key_enter) begin
            state_s = state_r;
          end else if ((state_r == PIECE_SEL) ? own_f(piece_s, player) : (!at_src_s && own_f(piece_s, player))) begin
            state_s = POS_SEL;
            src_x_s = cur_x_r;
            src_y_s = cur_y_r;
            sel_s   = piece_s;
          end else if (state_r == PIECE_SEL) begin
            state_s = PIECE_SEL;
          end else if (at_src_s) begin
            state_s = PIECE_SEL;
          end else begin
            state_s   = VAL_REQ;
            pkt_s     = {src_x_r, src_y_r, cur_x_r, cur_y_r};
            val_req_s = 1'b1;
            tmo_s     = {CW{1'b0}};
          end
        end
      end
      VAL_REQ: begin
        if (tmo_r == CW'(TIMEOUT - 1)) begin
          state_s     = POS_SEL;
          val_req_s   = 1'b0;
          timed_out_s = 1'b1;
          rejected_s  = 1'b1;
        end else if (val_ack) begin
          state_s   = VAL_WAIT;
          val_req_s = 1'b0;
          tmo_s     = tmo_r + CW'(1);
        end else begin
          tmo_s = tmo_r + CW'(1);
        end
      end
      VAL_WAIT: begin
        if (val_done && val_legal) begin
          state_s = WAIT_TURN;
          moved_s = 1'b1;
          count_s = move_count + 16'd1;
        end else if (val_done) begin
          state_s    = POS_SEL;
          rejected_s = 1'b1;
        end else if (tmo_r == CW'(TIMEOUT - 1)) begin
          state_s     = POS_SEL;
          timed_out_s = 1'b1;
          rejected_s  = 1'b1;
        end else begin
          tmo_s = tmo_r + CW'(1);
        end
      end
      default: begin
        state_s   = WAIT_TURN;
        val_req_s = 1'b0;
      end
    endcase
  end

  // Display image and highlight masks; the preview lifts the source and drops it on the cursor.
  always_comb begin
    for (int x = 0; x < BOARD_W; x++) begin
      for (int y = 0; y < BOARD_H; y++) begin
        if (preview_s && (x == int'(cur_x_r)) && (y == int'(cur_y_r))) begin
          disp_s[x][y] = sel_piece;
        end else if (preview_s && (x == int'(src_x_r)) && (y == int'(src_y_r))) begin
          disp_s[x][y] = PIECE_W'(EMPTY_CODE);
        end else begin
          disp_s[x][y] = stable_board[x][y];
        end
        cursor_hl[x][y] = cur_hl_en_s && (x == int'(cur_x_r)) && (y == int'(cur_y_r));
        src_hl[x][y]    = preview_s && (x == int'(src_x_r)) && (y == int'(src_y_r));
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r     <= WAIT_TURN;
      cur_x_r     <= XW'(HOME_X);
      cur_y_r     <= YW'(HOME_Y);
      src_x_r     <= XW'(HOME_X);
      src_y_r     <= YW'(HOME_Y);
      sel_piece   <= PIECE_W'(EMPTY_CODE);
      move_packet <= {PW{1'b0}};
      val_req     <= 1'b0;
      moved       <= 1'b0;
      rejected    <= 1'b0;
      timed_out   <= 1'b0;
      move_count  <= 16'd0;
      tmo_r       <= {CW{1'b0}};
      for (int x = 0; x < BOARD_W; x++) begin
        for (int y = 0; y < BOARD_H; y++) begin
          disp_board[x][y] <= PIECE_W'(EMPTY_CODE);
        end
      end
    end else begin
      state_r     <= state_s;
      cur_x_r     <= cur_x_s;
      cur_y_r     <= cur_y_s;
      src_x_r     <= src_x_s;
      src_y_r     <= src_y_s;
      sel_piece   <= sel_s;
      move_packet <= pkt_s;
      val_req     <= val_req_s;
      moved       <= moved_s;
      rejected    <= rejected_s;
      timed_out   <= timed_out_s;
      move_count  <= count_s;
      tmo_r       <= tmo_s;
      disp_board  <= disp_s;
    end
  end

endmodule

// File: tb/tb_move_select_ctrl.sv
// Bench for move_select_ctrl: a wrapping and a clamping instance share stimulus and
// are compared every cycle against a game-rule reference model.
module tb_move_select_ctrl;

  localparam int T = 15;
  localparam logic [2:0] S_WAIT = 3'd0, S_PIECE = 3'd1, S_POS = 3'd2, S_VREQ = 3'd3, S_VWAIT = 3'd4;

  logic clk = 1'b0, rst = 1'b1;
  logic enable = 1'b0, player = 1'b0, curr_player = 1'b0, dir = 1'b0;
  logic key_dec = 1'b0, key_inc = 1'b0, key_enter = 1'b0, key_cancel = 1'b0;
  logic val_ack = 1'b0, val_done = 1'b0, val_legal = 1'b0;
  logic [3:0] board [8][8];

  logic [3:0]  disp_a [8][8], disp_b [8][8];
  logic        chl_a [8][8], chl_b [8][8], shl_a [8][8], shl_b [8][8];
  logic        vreq_a, vreq_b, mv_a, mv_b, rj_a, rj_b, to_a, to_b;
  logic [11:0] pkt_a, pkt_b;
  logic [3:0]  sel_a, sel_b;
  logic [15:0] cnt_a, cnt_b;
  logic [2:0]  st_a, st_b;

  int n_checks = 0, n_errors = 0;

  // reference model state, index 0 = wrapping instance, 1 = clamping instance
  int m_st[2], m_cx[2], m_cy[2], m_sx[2], m_sy[2], m_sel[2];
  int m_px[2], m_py[2], m_dx[2], m_dy[2], m_age[2], m_cnt[2];
  bit m_vreq[2], m_mv[2], m_rj[2], m_to[2];
  logic [255:0] m_disp[2];

  always #5 clk = ~clk;

  move_select_ctrl #(.WRAP(1), .TIMEOUT(T)) dut_a (
    .CLOCK_50(clk), .reset(rst), .enable(enable), .player(player), .curr_player(curr_player),
    .dir(dir), .key_dec(key_dec), .key_inc(key_inc), .key_enter(key_enter), .key_cancel(key_cancel),
    .stable_board(board), .val_ack(val_ack), .val_done(val_done), .val_legal(val_legal),
    .disp_board(disp_a), .cursor_hl(chl_a), .src_hl(shl_a), .val_req(vreq_a), .move_packet(pkt_a),
    .sel_piece(sel_a), .moved(mv_a), .rejected(rj_a), .timed_out(to_a), .move_count(cnt_a), .state(st_a));

  move_select_ctrl #(.WRAP(0), .TIMEOUT(T)) dut_b (
    .CLOCK_50(clk), .reset(rst), .enable(enable), .player(player), .curr_player(curr_player),
    .dir(dir), .key_dec(key_dec), .key_inc(key_inc), .key_enter(key_enter), .key_cancel(key_cancel),
    .stable_board(board), .val_ack(val_ack), .val_done(val_done), .val_legal(val_legal),
    .disp_board(disp_b), .cursor_hl(chl_b), .src_hl(shl_b), .val_req(vreq_b), .move_packet(pkt_b),
    .sel_piece(sel_b), .moved(mv_b), .rejected(rj_b), .timed_out(to_b), .move_count(cnt_b), .state(st_b));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] flat4(input logic [3:0] b [8][8]);
    logic [255:0] r = '0;
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) r[(x*8+y)*4 +: 4] = b[x][y];
    return r;
  endfunction

  function automatic logic [63:0] flat1(input logic h [8][8]);
    logic [63:0] r = '0;
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) r[x*8+y] = h[x][y];
    return r;
  endfunction

  function automatic bit own(input int c, input logic p);
    return (c != 15) && (p ? (c <= 5) : (c > 5));
  endfunction

  function automatic int nudge(input int v, input int delta, input bit wrap);
    int n = v + delta;
    if (n < 0) n = wrap ? 7 : 0;
    if (n > 7) n = wrap ? 0 : 7;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_WAIT; m_cx[k] = 3; m_cy[k] = 3; m_sx[k] = 3; m_sy[k] = 3; m_sel[k] = 15;
      m_px[k] = 0; m_py[k] = 0; m_dx[k] = 0; m_dy[k] = 0; m_age[k] = 0; m_cnt[k] = 0;
      m_vreq[k] = 0; m_mv[k] = 0; m_rj[k] = 0; m_to[k] = 0; m_disp[k] = {64{4'hf}};
    end
  endtask

  task automatic model_step(input int k);
    int st = m_st[k], cx = m_cx[k], cy = m_cy[k], nx, ny, pc, c;
    bit wrap = (k == 0);
    bit showing = (st == S_POS) || (st == S_VREQ) || (st == S_VWAIT);
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) begin
      c = board[x][y];
      if (showing && x == cx && y == cy) c = m_sel[k];
      else if (showing && x == m_sx[k] && y == m_sy[k]) c = 15;
      m_disp[k][(x*8+y)*4 +: 4] = 4'(c);
    end
    m_mv[k] = 0; m_rj[k] = 0; m_to[k] = 0;
    pc = board[cx][cy];
    nx = cx; ny = cy;
    if (key_dec) begin
      if (dir) nx = nudge(cx, -1, wrap); else ny = nudge(cy, 1, wrap);
    end else if (key_inc) begin
      if (dir) nx = nudge(cx, 1, wrap); else ny = nudge(cy, -1, wrap);
    end
    if (st == S_WAIT) begin
      if (enable && player == curr_player) begin
        m_st[k] = S_PIECE; m_cx[k] = 3; m_cy[k] = 3; m_sx[k] = 3; m_sy[k] = 3;
      end
    end else if (st == S_PIECE || st == S_POS) begin
      if (player != curr_player) m_st[k] = S_WAIT;
      else if (enable && st == S_POS && key_cancel) begin
        m_cx[k] = m_sx[k]; m_cy[k] = m_sy[k]; m_st[k] = S_PIECE;
      end else if (enable) begin
        if (key_enter && st == S_PIECE && own(pc, player)) begin
          m_sx[k] = cx; m_sy[k] = cy; m_sel[k] = pc; m_st[k] = S_POS;
        end else if (key_enter && st == S_POS && cx == m_sx[k] && cy == m_sy[k]) begin
          m_st[k] = S_PIECE;
        end else if (key_enter && st == S_POS && own(pc, player)) begin
          m_sx[k] = cx; m_sy[k] = cy; m_sel[k] = pc;
        end else if (key_enter && st == S_POS) begin
          m_px[k] = m_sx[k]; m_py[k] = m_sy[k]; m_dx[k] = cx; m_dy[k] = cy;
          m_st[k] = S_VREQ; m_vreq[k] = 1; m_age[k] = 0;
        end
        m_cx[k] = nx; m_cy[k] = ny;
      end
    end else begin
      m_age[k]++;  // cycles elapsed since the request went out, including this one
      if (st == S_VWAIT && val_done) begin
        if (val_legal) begin
          m_mv[k] = 1; m_cnt[k] = (m_cnt[k] + 1) % 65536; m_st[k] = S_WAIT;
        end else begin
          m_rj[k] = 1; m_st[k] = S_POS;
        end
      end else if (m_age[k] >= T) begin
        m_to[k] = 1; m_rj[k] = 1; m_vreq[k] = 0; m_st[k] = S_POS;
      end else if (st == S_VREQ && val_ack) begin
        m_vreq[k] = 0; m_st[k] = S_VWAIT;
      end
    end
  endtask

  task automatic check_inst(input int k);
    string s = (k == 0) ? "a" : "b";
    logic [63:0] exp_ch = '0, exp_sh = '0;
    if ((m_st[k] == S_PIECE || m_st[k] == S_POS) && player == curr_player) exp_ch[m_cx[k]*8 + m_cy[k]] = 1'b1;
    if (m_st[k] == S_POS || m_st[k] == S_VREQ || m_st[k] == S_VWAIT) exp_sh[m_sx[k]*8 + m_sy[k]] = 1'b1;
    check({s, "_state"},  256'(k == 0 ? st_a : st_b), 256'(m_st[k]));
    check({s, "_val_req"}, 256'(k == 0 ? vreq_a : vreq_b), 256'(m_vreq[k]));
    check({s, "_packet"}, 256'(k == 0 ? pkt_a : pkt_b),
          256'({3'(m_px[k]), 3'(m_py[k]), 3'(m_dx[k]), 3'(m_dy[k])}));
    check({s, "_sel_piece"}, 256'(k == 0 ? sel_a : sel_b), 256'(m_sel[k]));
    check({s, "_moved"}, 256'(k == 0 ? mv_a : mv_b), 256'(m_mv[k]));
    check({s, "_rejected"}, 256'(k == 0 ? rj_a : rj_b), 256'(m_rj[k]));
    check({s, "_timed_out"}, 256'(k == 0 ? to_a : to_b), 256'(m_to[k]));
    check({s, "_move_count"}, 256'(k == 0 ? cnt_a : cnt_b), 256'(m_cnt[k]));
    check({s, "_cursor_hl"}, 256'(k == 0 ? flat1(chl_a) : flat1(chl_b)), 256'(exp_ch));
    check({s, "_src_hl"}, 256'(k == 0 ? flat1(shl_a) : flat1(shl_b)), 256'(exp_sh));
    check({s, "_disp"}, k == 0 ? flat4(disp_a) : flat4(disp_b), m_disp[k]);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    key_dec = 1'b0; key_inc = 1'b0; key_enter = 1'b0; key_cancel = 1'b0;
    val_ack = 1'b0; val_done = 1'b0;
  endtask

  task automatic press(input int which, input int times);
    for (int i = 0; i < times; i++) begin
      if (which == 0) key_dec = 1'b1; else key_inc = 1'b1;
      tick();
    end
  endtask

  task automatic rand_board();
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) begin
      case ($urandom_range(0, 3))
        0, 1:    board[x][y] = 4'hf;
        2:       board[x][y] = 4'($urandom_range(0, 5));
        default: board[x][y] = 4'($urandom_range(6, 14));
      endcase
    end
  endtask

  initial begin
    int vlen;
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) board[x][y] = 4'hf;
    board[3][3] = 4'd2; board[5][5] = 4'd9; board[0][3] = 4'd1;
    model_reset();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    rst = 1'b0;

    // turn start
    player = 1'b1; curr_player = 1'b1; enable = 1'b1; dir = 1'b1;
    tick();
    check("start_state", 256'(st_a), 256'(S_PIECE));
    check("start_hl33", 256'(chl_a[3][3]), 256'd1);

    // edge behaviour: a wraps, b clamps
    press(0, 3);
    press(0, 1);
    check("wrap_dec_x7", 256'(chl_a[7][3]), 256'd1);
    check("clamp_dec_x0", 256'(chl_b[0][3]), 256'd1);
    press(1, 7);
    press(1, 1);
    check("clamp_inc_x7", 256'(chl_b[7][3]), 256'd1);
    press(0, 4);

    // legal move (3,3)->(3,5)
    key_enter = 1'b1; tick();
    dir = 1'b0; press(0, 2);
    tick();
    check("preview_dst", 256'(disp_a[3][5]), 256'd2);
    check("preview_src", 256'(disp_a[3][3]), 256'hf);
    key_enter = 1'b1; tick();
    check("pkt", 256'(pkt_a), 256'({3'd3, 3'd3, 3'd3, 3'd5}));
    check("req_up", 256'(vreq_a), 256'd1);
    val_ack = 1'b1; tick();
    tick(); tick();
    val_done = 1'b1; val_legal = 1'b1; tick();
    check("moved", 256'(mv_a), 256'd1);
    check("count1", 256'(cnt_a), 256'd1);
    check("after_move", 256'(st_a), 256'(S_WAIT));
    tick();
    check("moved_1cyc", 256'(mv_a), 256'd0);

    // rejected move
    key_enter = 1'b1; tick();
    press(0, 2);
    key_enter = 1'b1; tick();
    val_ack = 1'b1; tick();
    val_done = 1'b1; val_legal = 1'b0; tick();
    check("rej", 256'(rj_a), 256'd1);
    check("rej_state", 256'(st_a), 256'(S_POS));
    check("rej_src_hl", 256'(shl_a[3][3]), 256'd1);
    check("rej_cursor", 256'(chl_a[3][5]), 256'd1);

    // cancel beats enter
    key_cancel = 1'b1; key_enter = 1'b1; tick();
    check("cancel_state", 256'(st_a), 256'(S_PIECE));
    check("cancel_cursor", 256'(chl_a[3][3]), 256'd1);

    // timeout with no ack
    key_enter = 1'b1; tick();
    press(0, 2);
    key_enter = 1'b1; tick();
    vlen = vreq_a ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vreq_a) vlen++;
      else break;
    end
    check("tmo_len", 256'(vlen), 256'(T));
    check("tmo_pulse", 256'({to_a, rj_a}), 256'(2'b11));

    // reselect another own piece
    press(1, 2);
    dir = 1'b1; press(0, 3);
    key_enter = 1'b1; tick();
    check("resel_piece", 256'(sel_a), 256'd1);
    check("resel_src", 256'(shl_a[0][3]), 256'd1);

    // turn loss
    curr_player = 1'b0; tick();
    check("turn_loss", 256'(st_a), 256'(S_WAIT));
    curr_player = 1'b1; tick();

    // asynchronous reset mid-handshake
    key_enter = 1'b1; tick();
    dir = 1'b0; press(0, 1);
    key_enter = 1'b1; tick();
    check("pre_rst_req", 256'(vreq_a), 256'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req", 256'(vreq_a), 256'd0);
    check("rst_count", 256'(cnt_a), 256'd0);
    model_reset();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    rst = 1'b0;

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        rand_board();
        player = 1'($urandom_range(0, 1));
      end
      enable      = ($urandom_range(0, 15) != 0);
      curr_player = ($urandom_range(0, 40) == 0) ? ~player : player;
      dir         = 1'($urandom_range(0, 1));
      key_dec     = ($urandom_range(0, 3) == 0);
      key_inc     = ($urandom_range(0, 3) == 0);
      key_enter   = ($urandom_range(0, 4) == 0);
      key_cancel  = ($urandom_range(0, 9) == 0);
      val_ack     = ($urandom_range(0, 2) == 0);
      val_done    = ($urandom_range(0, ((i / 500) % 2 == 1) ? 12 : 3) == 0);
      val_legal   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
